// File: rtl/processor_stage2.sv
// Decode/register-read stage: splits 18-bit code words, reads two operands and
// joins two-word long immediates. Optional same-cycle write bypass: PROCESSOR_STAGE2_BYPASS_EN.
module processor_stage2 #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 no_operation_in,
  input  logic [ADDR_SIZE-1:0] ip_in,
  input  logic [WORD_SIZE-1:0] code_word_in,
  input  logic                 flush,
  input  logic                 reg_write_en,
  input  logic [2:0]           reg_write_addr,
  input  logic [WORD_SIZE-1:0] reg_write_data,
  output logic                 no_operation_out,
  output logic [ADDR_SIZE-1:0] ip_out,
  output logic [3:0]           opcode_out,
  output logic [2:0]           dst_out,
  output logic [WORD_SIZE-1:0] src0_out,
  output logic [WORD_SIZE-1:0] src1_out,
  output logic [WORD_SIZE-1:0] imm_out
);

  typedef enum logic {IDLE, WAIT_IMM} state_t;

  localparam logic [3:0] LONG_OPCODE = 4'hF;

  state_t               state;
  logic [WORD_SIZE-1:0] regs [8];

  // Header of a long op, held while waiting for its immediate word
  logic [ADDR_SIZE-1:0] hdr_ip;
  logic [3:0]           hdr_opcode;
  logic [2:0]           hdr_rd;
  logic [2:0]           hdr_ra;
  logic [2:0]           hdr_rb;

  logic [3:0]           word_opcode;
  logic [2:0]           word_rd;
  logic [2:0]           word_ra;
  logic [2:0]           word_rb;
  logic [7:0]           word_imm8;
  logic [WORD_SIZE-1:0] short_imm;

  assign word_opcode = code_word_in[17:14];
  assign word_rd     = code_word_in[13:11];
  assign word_ra     = code_word_in[10:8];
  assign word_rb     = code_word_in[7:5];
  assign word_imm8   = code_word_in[7:0];
  assign short_imm   = {{(WORD_SIZE-8){word_imm8[7]}}, word_imm8};

  logic [2:0]           read_idx0;
  logic [2:0]           read_idx1;
  logic [WORD_SIZE-1:0] read_val0;
  logic [WORD_SIZE-1:0] read_val1;

  // Long ops re-read operands in the immediate cycle using the held indices
  always_comb begin
    read_idx0 = (state == WAIT_IMM) ? hdr_ra : word_ra;
    read_idx1 = (state == WAIT_IMM) ? hdr_rb : word_rb;
`ifdef PROCESSOR_STAGE2_BYPASS_EN
    read_val0 = (reg_write_en && reg_write_addr == read_idx0) ? reg_write_data : regs[read_idx0];
    read_val1 = (reg_write_en && reg_write_addr == read_idx1) ? reg_write_data : regs[read_idx1];
`else
    read_val0 = regs[read_idx0];
    read_val1 = regs[read_idx1];
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      no_operation_out <= 1'b1;
      ip_out           <= '0;
      opcode_out       <= '0;
      dst_out          <= '0;
      src0_out         <= '0;
      src1_out         <= '0;
      imm_out          <= '0;
      hdr_ip           <= '0;
      hdr_opcode       <= '0;
      hdr_rd           <= '0;
      hdr_ra           <= '0;
      hdr_rb           <= '0;
      // NOTE: the register file is small and architecturally zero after reset, so it is reset like any flop.
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (reg_write_en) regs[reg_write_addr] <= reg_write_data;

      if (flush) begin
        no_operation_out <= 1'b1;
        state            <= IDLE;
      end else if (no_operation_in) begin
        no_operation_out <= 1'b1;
      end else if (state == IDLE) begin
        if (word_opcode == LONG_OPCODE) begin
          no_operation_out <= 1'b1;
          hdr_ip           <= ip_in;
          hdr_opcode       <= word_opcode;
          hdr_rd           <= word_rd;
          hdr_ra           <= word_ra;
          hdr_rb           <= word_rb;
          state            <= WAIT_IMM;
        end else begin
          no_operation_out <= 1'b0;
          ip_out           <= ip_in;
          opcode_out       <= word_opcode;
          dst_out          <= word_rd;
          src0_out         <= read_val0;
          src1_out         <= read_val1;
          imm_out          <= short_imm;
        end
      end else begin
        no_operation_out <= 1'b0;
        ip_out           <= hdr_ip;
        opcode_out       <= hdr_opcode;
        dst_out          <= hdr_rd;
        src0_out         <= read_val0;
        src1_out         <= read_val1;
        imm_out          <= code_word_in;
        state            <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_processor_stage2.sv
// Scoreboard bench for processor_stage2: a behavioural model pushes the expected
// output for each driven word; it is popped and compared one cycle later.
module tb_processor_stage2;

  logic        clock = 1'b0;
  logic        reset;
  logic        no_operation_in;
  logic [17:0] ip_in;
  logic [17:0] code_word_in;
  logic        flush;
  logic        reg_write_en;
  logic [2:0]  reg_write_addr;
  logic [17:0] reg_write_data;
  logic        no_operation_out;
  logic [17:0] ip_out;
  logic [3:0]  opcode_out;
  logic [2:0]  dst_out;
  logic [17:0] src0_out;
  logic [17:0] src1_out;
  logic [17:0] imm_out;

  processor_stage2 dut (
    .clock(clock), .reset(reset),
    .no_operation_in(no_operation_in), .ip_in(ip_in), .code_word_in(code_word_in),
    .flush(flush), .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .no_operation_out(no_operation_out),
    .ip_out(ip_out), .opcode_out(opcode_out), .dst_out(dst_out),
    .src0_out(src0_out), .src1_out(src1_out), .imm_out(imm_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        nop;
    logic [17:0] ip;
    logic [3:0]  op;
    logic [2:0]  dst;
    logic [17:0] s0;
    logic [17:0] s1;
    logic [17:0] imm;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [17:0] m_rf [8];
  logic        m_wait;
  logic [17:0] h_ip;
  logic [3:0]  h_op;
  logic [2:0]  h_rd, h_ra, h_rb;
  out_t        m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_wait = 1'b0;
    h_ip = '0; h_op = '0; h_rd = '0; h_ra = '0; h_rb = '0;
    m_last = '0;
    m_last.nop = 1'b1;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; no_operation_in = 1'b1; ip_in = '0; code_word_in = '0;
    flush = 1'b0; reg_write_en = 1'b0; reg_write_addr = '0; reg_write_data = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    check("rst_nop",  32'(no_operation_out), 32'd1);
    check("rst_ip",   32'(ip_out),   32'd0);
    check("rst_op",   32'(opcode_out), 32'd0);
    check("rst_dst",  32'(dst_out),  32'd0);
    check("rst_src0", 32'(src0_out), 32'd0);
    check("rst_src1", 32'(src1_out), 32'd0);
    check("rst_imm",  32'(imm_out),  32'd0);
  endtask

  // One cycle: drive inputs, predict, clock, compare all outputs
  task automatic step(input logic nop_in, input logic [17:0] ip, input logic [17:0] word,
                      input logic fl, input logic we, input logic [2:0] wa, input logic [17:0] wd);
    logic [2:0]  i0, i1;
    logic [17:0] v0, v1;
    out_t        e, got;
    no_operation_in = nop_in; ip_in = ip; code_word_in = word; flush = fl;
    reg_write_en = we; reg_write_addr = wa; reg_write_data = wd;

    i0 = m_wait ? h_ra : word[10:8];
    i1 = m_wait ? h_rb : word[7:5];
    v0 = m_rf[i0];
    v1 = m_rf[i1];
`ifdef PROCESSOR_STAGE2_BYPASS_EN
    if (we && wa == i0) v0 = wd;
    if (we && wa == i1) v1 = wd;
`endif
    e = m_last;
    e.nop = 1'b1;
    if (fl) begin
      m_wait = 1'b0;
    end else if (!nop_in) begin
      if (!m_wait) begin
        if (word[17:14] == 4'hF) begin
          h_ip = ip; h_op = word[17:14]; h_rd = word[13:11]; h_ra = word[10:8]; h_rb = word[7:5];
          m_wait = 1'b1;
        end else begin
          e.nop = 1'b0; e.ip = ip; e.op = word[17:14]; e.dst = word[13:11];
          e.s0 = v0; e.s1 = v1; e.imm = {{10{word[7]}}, word[7:0]};
        end
      end else begin
        e.nop = 1'b0; e.ip = h_ip; e.op = h_op; e.dst = h_rd;
        e.s0 = v0; e.s1 = v1; e.imm = word;
        m_wait = 1'b0;
      end
    end
    m_last = e;
    if (we) m_rf[wa] = wd;
    exp_q.push_back(e);

    @(posedge clock); #1;
    got = '{no_operation_out, ip_out, opcode_out, dst_out, src0_out, src1_out, imm_out};
    e = exp_q.pop_front();
    check("nop",  32'(got.nop), 32'(e.nop));
    check("ip",   32'(got.ip),  32'(e.ip));
    check("op",   32'(got.op),  32'(e.op));
    check("dst",  32'(got.dst), 32'(e.dst));
    check("src0", 32'(got.s0),  32'(e.s0));
    check("src1", 32'(got.s1),  32'(e.s1));
    check("imm",  32'(got.imm), 32'(e.imm));
  endtask

  task automatic bubble();
    step(1'b1, 18'd0, 18'd0, 1'b0, 1'b0, 3'd0, 18'd0);
  endtask

  task automatic word(input logic [17:0] ip, input logic [17:0] w);
    step(1'b0, ip, w, 1'b0, 1'b0, 3'd0, 18'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    bubble();

    // First short op after reset
    word(18'd5, 18'h0_1234);
    check("first_ip", 32'(ip_out), 32'd5);
    check("first_imm", 32'(imm_out), 32'h00034);

    // Register write then read through both ports, positive and negative imm8
    step(1'b1, 18'd0, 18'd0, 1'b0, 1'b1, 3'd3, 18'h2AAAA);
    word(18'd6, {4'h1, 3'd4, 3'd3, 8'h70});
    check("r3_src0", 32'(src0_out), 32'h2AAAA);
    check("r3_src1", 32'(src1_out), 32'h2AAAA);
    word(18'd7, {4'h2, 3'd1, 3'd3, 8'hF0});
    check("neg_imm", 32'(imm_out), 32'h3FFF0);

    // Long op with a bubble between header and immediate
    word(18'd10, {4'hF, 3'd2, 3'd3, 8'h60});
    check("long_hdr_bubble", 32'(no_operation_out), 32'd1);
    bubble();
    check("long_wait_bubble", 32'(no_operation_out), 32'd1);
    word(18'd11, 18'h3ABCD);
    check("long_nop", 32'(no_operation_out), 32'd0);
    check("long_ip", 32'(ip_out), 32'd10);
    check("long_dst", 32'(dst_out), 32'd2);
    check("long_imm", 32'(imm_out), 32'h3ABCD);
    bubble();

    // Operand write landing between header and immediate is picked up
    word(18'd20, {4'hF, 3'd5, 3'd6, 8'hE0});
    step(1'b1, 18'd0, 18'd0, 1'b0, 1'b1, 3'd6, 18'h12345);
    word(18'd21, 18'h00042);
    check("long_reread", 32'(src0_out), 32'h12345);

    // Flush on the immediate word; next F word starts a fresh long op
    word(18'd30, {4'hF, 3'd1, 3'd0, 8'h00});
    step(1'b0, 18'd31, 18'h3FFFF, 1'b1, 1'b0, 3'd0, 18'd0);
    check("flush_bubble", 32'(no_operation_out), 32'd1);
    word(18'd40, {4'hF, 3'd7, 3'd1, 8'h20});
    check("post_flush_hdr", 32'(no_operation_out), 32'd1);
    word(18'd41, 18'h15555);
    check("post_flush_ip", 32'(ip_out), 32'd40);
    check("post_flush_imm", 32'(imm_out), 32'h15555);

    // Same-cycle write and read of r1
    step(1'b1, 18'd0, 18'd0, 1'b0, 1'b1, 3'd1, 18'd5);
    step(1'b0, 18'd50, {4'h3, 3'd2, 3'd1, 8'h00}, 1'b0, 1'b1, 3'd1, 18'd7);
`ifdef PROCESSOR_STAGE2_BYPASS_EN
    check("same_cycle_src0", 32'(src0_out), 32'd7);
`else
    check("same_cycle_src0", 32'(src0_out), 32'd5);
`endif

    // Reset while waiting for an immediate, then a short op
    word(18'd60, {4'hF, 3'd3, 3'd2, 8'h40});
    do_reset();
    word(18'd61, {4'h4, 3'd6, 3'd0, 8'h81});
    check("rst_mid_nop", 32'(no_operation_out), 32'd0);
    check("rst_mid_op", 32'(opcode_out), 32'd4);
    check("rst_mid_dst", 32'(dst_out), 32'd6);
    check("rst_mid_ip", 32'(ip_out), 32'd61);
    check("rst_mid_imm", 32'(imm_out), 32'h3FF81);

    // Random mix of words, bubbles, flushes and writes
    for (int n = 0; n < 300; n++) begin
      logic [17:0] w;
      w = 18'($urandom);
      if ($urandom_range(0, 3) == 0) w[17:14] = 4'hF;
      step(($urandom_range(0, 4) == 0), 18'($urandom), w, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1), 3'($urandom), 18'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
